// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-read-port register file with write-first forwarding and a post-reset clear sweep.
// Defining REG_BANK_DEBUG_EN adds a raw (unforwarded) debug read port.
module register_bank_mp #(
    parameter int REG_WIDTH     = 32,
    parameter int REG_ADDR_BITS = 5,
    parameter int NUM_READ      = 2,
    parameter int ZERO_REG      = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              write_w,
    input  logic [REG_ADDR_BITS-1:0]          addr_reg_w,
    input  logic [REG_WIDTH-1:0]              reg_w_data_in,
    input  logic [NUM_READ*REG_ADDR_BITS-1:0] rd_addr,
    output logic [NUM_READ*REG_WIDTH-1:0]     rd_data,
`ifdef REG_BANK_DEBUG_EN
    output logic                              ready,
    input  logic [REG_ADDR_BITS-1:0]          debug_addr,
    output logic [REG_WIDTH-1:0]              debug_data
`else
    output logic                              ready
`endif
);
    localparam int DEPTH = 1 << REG_ADDR_BITS;
    localparam logic [REG_ADDR_BITS-1:0] LAST = REG_ADDR_BITS'(DEPTH - 1);
    localparam bit ZR = ZERO_REG != 0;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                                 state_q, state_d;
    logic [REG_ADDR_BITS-1:0]               clr_ptr_q, clr_ptr_d;
    logic                                   ready_q, ready_d;
    logic [NUM_READ-1:0][REG_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic [NUM_READ-1:0][REG_ADDR_BITS-1:0] ra;
    logic [REG_WIDTH-1:0]                   reg_vec [DEPTH];
    logic                                   we;
    logic [REG_ADDR_BITS-1:0]               waddr;
    logic [REG_WIDTH-1:0]                   wdata;

    assign ra      = rd_addr;
    assign rd_data = rd_data_q;
    assign ready   = ready_q;

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
            rd_data_q <= rd_data_d;
        end
    end

    // The pointer wraps to 0 on the final sweep step, which is harmless since RUN never uses it.
    always_comb begin
        state_d   = (state_q == CLEAR && clr_ptr_q == LAST) ? RUN : state_q;
        clr_ptr_d = (state_q == CLEAR) ? clr_ptr_q + 1'b1 : clr_ptr_q;
    end

    always_comb begin
        ready_d = state_d == RUN;
        we      = state_q == CLEAR || (write_w && !(ZR && addr_reg_w == '0));
        waddr   = (state_q == CLEAR) ? clr_ptr_q : addr_reg_w;
        wdata   = (state_q == CLEAR) ? '0 : reg_w_data_in;
        for (int p = 0; p < NUM_READ; p++)
            rd_data_d[p] = (state_q != RUN || (ZR && ra[p] == '0)) ? '0 :
                           (write_w && addr_reg_w == ra[p]) ? reg_w_data_in : reg_vec[ra[p]];
    end

    always_ff @(negedge clk) begin
        if (!reset && we)
            reg_vec[waddr] <= wdata;
    end

`ifdef REG_BANK_DEBUG_EN
    logic [REG_WIDTH-1:0] debug_data_q;

    always_ff @(negedge clk) begin
        debug_data_q <= (reset || state_q != RUN || (ZR && debug_addr == '0)) ? '0 : reg_vec[debug_addr];
    end

    assign debug_data = debug_data_q;
`endif
endmodule

// File: tb/tb_register_bank_mp.sv
// tb_register_bank_mp: scoreboard bench for register_bank_mp (default parameters).
module tb_register_bank_mp;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_w = 1'b0;
    logic [4:0]  addr_reg_w = '0;
    logic [31:0] reg_w_data_in = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        ready;
`ifdef REG_BANK_DEBUG_EN
    logic [4:0]  debug_addr = '0;
    logic [31:0] debug_data;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mem [32];

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    register_bank_mp dut (
        .clk(clk),
        .reset(reset),
        .write_w(write_w),
        .addr_reg_w(addr_reg_w),
        .reg_w_data_in(reg_w_data_in),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
`ifdef REG_BANK_DEBUG_EN
        .ready(ready),
        .debug_addr(debug_addr),
        .debug_data(debug_data)
`else
        .ready(ready)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic we, input logic [4:0] wa, input logic [31:0] d, input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : (we && wa == a) ? d : mem[a];
    endfunction

    task automatic op(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] d,
                      input logic [4:0] a0, input logic [4:0] a1);
        write_w       = we;
        addr_reg_w    = wa;
        reg_w_data_in = d;
        rd_addr       = {a1, a0};
        sb.push_back('{tag, 0, model_rd(we, wa, d, a0)});
        sb.push_back('{tag, 1, model_rd(we, wa, d, a1)});
        @(negedge clk);
        #1;
        if (we && wa != 5'd0) mem[wa] = d;
        write_w = 1'b0;
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("%s_p%0d", e.tag, e.port), rd_data[e.port*32 +: 32], e.val);
        end
    endtask

    // Writes to r4 are driven throughout the sweep; they must be dropped.
    task automatic run_reset(input string tag, input int abort_at);
        int  n;
        bit  aborted;
        reset         = 1'b1;
        write_w       = 1'b1;
        addr_reg_w    = 5'd4;
        reg_w_data_in = 32'h0BAD_0BAD;
        rd_addr       = {5'd4, 5'd4};
        @(negedge clk);
        #1;
        check({tag, "_rst_ready"}, ready, 0);
        check({tag, "_rst_rd"}, rd_data, 0);
        reset   = 1'b0;
        n       = 0;
        aborted = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (n == 5) check({tag, "_sweep_rd"}, rd_data, 0);
            if (abort_at != 0 && n == abort_at && !aborted) begin
                aborted = 1;
                reset   = 1'b1;
                @(negedge clk);
                #1;
                reset = 1'b0;
                check({tag, "_abort_ready"}, ready, 0);
                n = 0;
            end
        end
        check({tag, "_sweep_len"}, n, 32);
        write_w = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  wa, a0, a1;
        logic [31:0] d;
        logic        we;
        run_reset("init", 0);
        for (int a = 0; a < 32; a += 2) op("clr", 0, 5'd0, 32'd0, 5'(a), 5'(a + 1));
        op("wr5", 1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
        op("rd5", 0, 5'd0, 32'd0, 5'd5, 5'd6);
        op("fwd7", 1, 5'd7, 32'h1234_5678, 5'd3, 5'd7);
        op("rd7", 0, 5'd0, 32'd0, 5'd7, 5'd7);
        op("wr0", 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        op("rd0", 0, 5'd0, 32'd0, 5'd0, 5'd0);
        op("wr31", 1, 5'd31, 32'h8000_0001, 5'd31, 5'd30);
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            d  = $urandom;
            a0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            op("rnd", we, wa, d, a0, a1);
        end
        op("wr3", 1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3);
        op("rd3", 0, 5'd0, 32'd0, 5'd3, 5'd3);
        run_reset("mid", 10);
        op("r3clr", 0, 5'd0, 32'd0, 5'd3, 5'd4);
        op("r5clr", 0, 5'd0, 32'd0, 5'd5, 5'd7);
`ifdef REG_BANK_DEBUG_EN
        op("wr9", 1, 5'd9, 32'h55, 5'd1, 5'd2);
        debug_addr = 5'd9;
        @(negedge clk);
        #1;
        check("dbg_r9", debug_data, 32'h55);
        op("wr9b", 1, 5'd9, 32'h66, 5'd9, 5'd9);
        check("dbg_nofwd", debug_data, 32'h55);
        @(negedge clk);
        #1;
        check("dbg_r9b", debug_data, 32'h66);
        debug_addr = 5'd0;
        @(negedge clk);
        #1;
        check("dbg_r0", debug_data, 32'h0);
`endif
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
